rx78_keymatrix: RTL

- Upstream input stage for the RX-78 core. Converts the HPS ps2_key event word and the joystick words into the RX-78 keyboard/joystick matrix.
- The CPU side writes a strobe (column select) and reads back an 8-bit row value.
- Key presses are latched until the CPU has scanned the owning column, so short taps are never lost between scans.

---
 rtl/rx78_keymatrix.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rx78_keymatrix.sv
// ---------------------------------------------------------------------------
// rx78_keymatrix
//   Input stage for the RX-78 core. It converts the HPS ps2_key event word and
//   the two joystick words into the RX-78 keyboard/joystick matrix that the
//   CPU scans through its strobe/row ports.
//
//   Each key has a pressed bit (P), a pending-release bit (R) and an unscanned
//   flag. A key that is pressed and released between two CPU scans stays
//   visible until its column has been read once, so short taps are never lost.
//
//   Optional feature macro: RX78_KBD_JOYMAP_EN
//     When defined, joystick 1 is also OR-ed onto the cursor keys and space
//     (column 8, strobe 9). This only affects the row output; P/R state is
//     left alone. When undefined, the joysticks appear only at
//     JOY1_SEL/JOY2_SEL.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   ps2_key[10:0]in   [10] toggle per event, [9] pressed, [8] E0, [7:0] code
//   joy1[31:0]   in   joystick 1: [0]R [1]L [2]D [3]U [4]Fire1 [5]Fire2
//   joy2[31:0]   in   joystick 2, same layout
//   strobe_wr    in   one-cycle CPU write pulse to the strobe port
//   strobe_data  in   written strobe value, only [3:0] used
//   col_rd       in   one-cycle CPU read pulse of the row port
//   key_data[7:0]out  row value for the current strobe, active-high
//   strobe[3:0]  out  currently latched strobe
//
// Column numbering: matrix column c (0-based) is selected by strobe c+1.
// The modifier column 9 (shift/ctrl) is therefore selected by strobe 10,
// the same value as JOY1_SEL; at that strobe the row is the OR of the
// modifier column and joystick 1.
// ---------------------------------------------------------------------------
module rx78_keymatrix #(
  parameter int         NCOLS    = 9,
  parameter logic [3:0] JOY1_SEL = 4'hA,
  parameter logic [3:0] JOY2_SEL = 4'hB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joy1,
  input  logic [31:0] joy2,
  input  logic        strobe_wr,
  input  logic [7:0]  strobe_data,
  input  logic        col_rd,
  output logic [7:0]  key_data,
  output logic [3:0]  strobe
);

  // Keyboard columns plus the modifier column that sits right after them.
  localparam int         MCOLS    = NCOLS + 1;
  localparam logic [3:0] LAST_SEL = 4'(MCOLS);
`ifdef RX78_KBD_JOYMAP_EN
  localparam logic [3:0] CUR_SEL  = 4'd9;   // strobe of cursor/space column 8
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [MCOLS-1:0][7:0] p_q, p_d;      // pressed
  logic [MCOLS-1:0][7:0] r_q, r_d;      // release pending until scanned
  logic [MCOLS-1:0][7:0] uns_q, uns_d;  // pressed since last scan of column
  logic [1:0]            held_q, held_d;// left/right shift physically held
  logic                  tog_q;
  logic                  init_q;        // tog_q holds a valid history
  logic [3:0]            strobe_q;
  logic [7:0]            kd_q, kd_d;

  logic [5:0] unused_bits;
  assign unused_bits = {^joy1[31:6], ^joy2[31:6], ^strobe_data[7:4], 3'b000};

  // -------------------------------------------------------------------------
  // Keymap: {ext,code} -> {valid, col[3:0], bit[2:0]}
  // -------------------------------------------------------------------------
  function automatic logic [7:0] keymap(input logic [8:0] k);
    logic [7:0] m;
    m = 8'h00;
    case (k)
      // column 0: digits 0-7
      9'h045: m = {1'b1, 4'd0, 3'd0};
      9'h016: m = {1'b1, 4'd0, 3'd1};
      9'h01E: m = {1'b1, 4'd0, 3'd2};
      9'h026: m = {1'b1, 4'd0, 3'd3};
      9'h025: m = {1'b1, 4'd0, 3'd4};
      9'h02E: m = {1'b1, 4'd0, 3'd5};
      9'h036: m = {1'b1, 4'd0, 3'd6};
      9'h03D: m = {1'b1, 4'd0, 3'd7};
      // column 1: 8 9 : ; , - . /
      9'h03E: m = {1'b1, 4'd1, 3'd0};
      9'h046: m = {1'b1, 4'd1, 3'd1};
      9'h052: m = {1'b1, 4'd1, 3'd2};
      9'h04C: m = {1'b1, 4'd1, 3'd3};
      9'h041: m = {1'b1, 4'd1, 3'd4};
      9'h04E: m = {1'b1, 4'd1, 3'd5};
      9'h049: m = {1'b1, 4'd1, 3'd6};
      9'h04A: m = {1'b1, 4'd1, 3'd7};
      // column 2: @ A-G
      9'h054: m = {1'b1, 4'd2, 3'd0};
      9'h01C: m = {1'b1, 4'd2, 3'd1};
      9'h032: m = {1'b1, 4'd2, 3'd2};
      9'h021: m = {1'b1, 4'd2, 3'd3};
      9'h023: m = {1'b1, 4'd2, 3'd4};
      9'h024: m = {1'b1, 4'd2, 3'd5};
      9'h02B: m = {1'b1, 4'd2, 3'd6};
      9'h034: m = {1'b1, 4'd2, 3'd7};
      // column 3: H-O
      9'h033: m = {1'b1, 4'd3, 3'd0};
      9'h043: m = {1'b1, 4'd3, 3'd1};
      9'h03B: m = {1'b1, 4'd3, 3'd2};
      9'h042: m = {1'b1, 4'd3, 3'd3};
      9'h04B: m = {1'b1, 4'd3, 3'd4};
      9'h03A: m = {1'b1, 4'd3, 3'd5};
      9'h031: m = {1'b1, 4'd3, 3'd6};
      9'h044: m = {1'b1, 4'd3, 3'd7};
      // column 4: P-W
      9'h04D: m = {1'b1, 4'd4, 3'd0};
      9'h015: m = {1'b1, 4'd4, 3'd1};
      9'h02D: m = {1'b1, 4'd4, 3'd2};
      9'h01B: m = {1'b1, 4'd4, 3'd3};
      9'h02C: m = {1'b1, 4'd4, 3'd4};
      9'h03C: m = {1'b1, 4'd4, 3'd5};
      9'h02A: m = {1'b1, 4'd4, 3'd6};
      9'h01D: m = {1'b1, 4'd4, 3'd7};
      // column 5: X Y Z [ \ ^
      9'h022: m = {1'b1, 4'd5, 3'd0};
      9'h035: m = {1'b1, 4'd5, 3'd1};
      9'h01A: m = {1'b1, 4'd5, 3'd2};
      9'h05B: m = {1'b1, 4'd5, 3'd3};
      9'h05D: m = {1'b1, 4'd5, 3'd4};
      9'h055: m = {1'b1, 4'd5, 3'd5};
      // column 6: function keys F1-F5
      9'h005: m = {1'b1, 4'd6, 3'd0};
      9'h006: m = {1'b1, 4'd6, 3'd1};
      9'h004: m = {1'b1, 4'd6, 3'd2};
      9'h00C: m = {1'b1, 4'd6, 3'd3};
      9'h003: m = {1'b1, 4'd6, 3'd4};
      // column 7: enter, backspace, esc, tab
      9'h05A: m = {1'b1, 4'd7, 3'd0};
      9'h066: m = {1'b1, 4'd7, 3'd1};
      9'h076: m = {1'b1, 4'd7, 3'd2};
      9'h00D: m = {1'b1, 4'd7, 3'd3};
      // column 8: ins, space, home, del, cursor U D L R
      9'h170: m = {1'b1, 4'd8, 3'd0};
      9'h029: m = {1'b1, 4'd8, 3'd1};
      9'h16C: m = {1'b1, 4'd8, 3'd2};
      9'h171: m = {1'b1, 4'd8, 3'd3};
      9'h175: m = {1'b1, 4'd8, 3'd4};
      9'h172: m = {1'b1, 4'd8, 3'd5};
      9'h16B: m = {1'b1, 4'd8, 3'd6};
      9'h174: m = {1'b1, 4'd8, 3'd7};
      // column 9: both shifts share bit 0, ctrl
      9'h012: m = {1'b1, 4'd9, 3'd0};
      9'h059: m = {1'b1, 4'd9, 3'd0};
      9'h014: m = {1'b1, 4'd9, 3'd1};
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Joystick word -> row {0,0,U,D,L,R,F1,F2}.
  function automatic logic [7:0] joy_row(input logic [5:0] j);
    return {2'b00, j[3], j[2], j[1], j[0], j[4], j[5]};
  endfunction

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic [8:0] kcode;
  logic [7:0] km;
  logic       km_valid;
  logic [3:0] kcol;
  logic [2:0] kbit;
  logic       is_shl, is_shr;
  logic       ev, make;
  logic       rd_hit, sel_col;
  logic [3:0] rd_col;

  assign kcode    = ps2_key[8:0];
  assign km       = keymap(kcode);
  assign kcol     = km[6:3];
  assign kbit     = km[2:0];
  assign km_valid = km[7] && (kcol < LAST_SEL);
  assign is_shl   = (kcode == 9'h012);
  assign is_shr   = (kcode == 9'h059);
  assign ev       = init_q && (ps2_key[10] != tog_q);
  assign make     = ps2_key[9];
  assign sel_col  = (strobe_q != 4'd0) && (strobe_q <= LAST_SEL);
  assign rd_hit   = col_rd && sel_col;
  assign rd_col   = strobe_q - 4'd1;

  // -------------------------------------------------------------------------
  // Matrix next state. The column scan is applied first so an event in the
  // same cycle overrides it for its own key (a make stays unscanned).
  // -------------------------------------------------------------------------
  logic rel_ok;

  always_comb begin
    p_d    = p_q;
    r_d    = r_q;
    uns_d  = uns_q;
    held_d = held_q;
    rel_ok = 1'b1;

    if (rd_hit) begin
      p_d[rd_col]   = p_q[rd_col] & ~r_q[rd_col];
      r_d[rd_col]   = 8'h00;
      uns_d[rd_col] = 8'h00;
    end

    if (ev && km_valid) begin
      if (make) begin
        p_d[kcol][kbit]   = 1'b1;
        r_d[kcol][kbit]   = 1'b0;
        uns_d[kcol][kbit] = 1'b1;
        if (is_shl) held_d[0] = 1'b1;
        if (is_shr) held_d[1] = 1'b1;
      end else begin
        // Shared shift bit only releases once both shifts are up.
        if (is_shl) begin
          held_d[0] = 1'b0;
          rel_ok    = ~held_q[1];
        end else if (is_shr) begin
          held_d[1] = 1'b0;
          rel_ok    = ~held_q[0];
        end
        if (rel_ok && p_d[kcol][kbit]) begin
          if (uns_d[kcol][kbit]) begin
            r_d[kcol][kbit] = 1'b1;
          end else begin
            p_d[kcol][kbit] = 1'b0;
            r_d[kcol][kbit] = 1'b0;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Row output
  // -------------------------------------------------------------------------
  always_comb begin
    kd_d = 8'h00;
    if (sel_col)               kd_d = p_q[rd_col];
    if (strobe_q == JOY1_SEL)  kd_d = kd_d | joy_row(joy1[5:0]);
    if (strobe_q == JOY2_SEL)  kd_d = kd_d | joy_row(joy2[5:0]);
`ifdef RX78_KBD_JOYMAP_EN
    // Joystick 1 doubles as cursor keys (bits 7..4 = R L D U) and space.
    if (strobe_q == CUR_SEL)
      kd_d = kd_d | {joy1[0], joy1[1], joy1[2], joy1[3], 2'b00, joy1[4], 1'b0};
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q      <= '0;
      r_q      <= '0;
      uns_q    <= '0;
      held_q   <= '0;
      tog_q    <= 1'b0;
      init_q   <= 1'b0;
      strobe_q <= 4'd0;
      kd_q     <= 8'h00;
    end else begin
      // First clock after reset only captures the toggle history.
      init_q <= 1'b1;
      tog_q  <= ps2_key[10];
      if (strobe_wr) strobe_q <= strobe_data[3:0];
      p_q    <= p_d;
      r_q    <= r_d;
      uns_q  <= uns_d;
      held_q <= held_d;
      kd_q   <= kd_d;
    end
  end

  assign key_data = kd_q;
  assign strobe   = strobe_q;

endmodule
